// File: rtl/config_loader_pkg.sv
// config_loader_pkg: shared FSM states, header commands and default sync word for the frame loader
package config_loader_pkg;
   typedef enum logic [2:0] {IDLE, HEADER, DATA, STROBE, HOLD} state_t;
   localparam logic [3:0] CMD_WRITE = 4'h1;
   localparam logic [3:0] CMD_END = 4'h2;
   localparam logic [31:0] DEFAULT_SYNC_WORD = 32'hFAB0FAB1;
endpackage

// File: rtl/frame_strobe_decoder.sv
// frame_strobe_decoder: one-hot decode of a frame address, all zero when disabled or out of range
module frame_strobe_decoder #(
   parameter int NUM_FRAMES = 20
) (
   input logic [7:0] addr,
   input logic en,
   output logic [NUM_FRAMES-1:0] strobe
);
   always_comb begin
      strobe = '0;
      for (int i = 0; i < NUM_FRAMES; i++) strobe[i] = en && addr == 8'(i);
   end
endmodule

// File: rtl/config_frame_loader.sv
// config_frame_loader: parses a bitstream word stream and writes frames into level-sensitive config latches
module config_frame_loader
   import config_loader_pkg::*;
#(
   parameter int FRAME_WIDTH = 32,
   parameter int NUM_FRAMES = 20,
   parameter int STROBE_CYCLES = 2,
   parameter logic [31:0] SYNC_WORD = DEFAULT_SYNC_WORD
) (
   input logic CLK,
   input logic RST,
   input logic [31:0] WordIn,
   input logic WordValid,
   output logic WordReady,
   output logic [FRAME_WIDTH-1:0] FrameData,
   output logic [NUM_FRAMES-1:0] FrameStrobe,
   output logic ConfigActive,
   output logic ConfigDone,
   output logic ErrBadAddr
);
   localparam int CW = $clog2(STROBE_CYCLES) + 1;
   state_t state, state_n;
   logic [7:0] addr;
   logic [CW-1:0] cnt, cnt_n;
   logic [NUM_FRAMES-1:0] strobe_n;
   logic xfer, is_sync, in_range, hdr_write, hdr_end;
   assign WordReady = state inside {IDLE, HEADER, DATA};
   assign xfer = WordValid & WordReady;
   assign is_sync = WordIn == SYNC_WORD;
   assign in_range = int'(addr) < NUM_FRAMES;
   assign hdr_write = state == HEADER && xfer && !is_sync && WordIn[31:28] == CMD_WRITE;
   assign hdr_end = state == HEADER && xfer && !is_sync && WordIn[31:28] == CMD_END;
   always_comb begin
      state_n = state;
      cnt_n = cnt;
      case (state)
         IDLE: state_n = xfer && is_sync ? HEADER : IDLE;
         HEADER: state_n = hdr_write ? DATA : hdr_end ? IDLE : HEADER;
         DATA: begin
            state_n = !xfer ? DATA : in_range ? STROBE : HEADER;
            cnt_n = '0;
         end
         STROBE: begin
            cnt_n = cnt + 1'b1;
            state_n = cnt == CW'(STROBE_CYCLES - 1) ? HOLD : STROBE;
         end
         HOLD: state_n = HEADER;
         default: state_n = IDLE;
      endcase
   end
   // Strobe is registered from the next state so the latch enables come straight off flops
   frame_strobe_decoder #(.NUM_FRAMES(NUM_FRAMES)) u_dec (
      .addr(addr),
      .en(state_n == STROBE),
      .strobe(strobe_n)
   );
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
         cnt <= '0;
         addr <= '0;
         FrameData <= '0;
         FrameStrobe <= '0;
         ConfigActive <= 1'b0;
         ConfigDone <= 1'b0;
         ErrBadAddr <= 1'b0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         FrameStrobe <= strobe_n;
         if (hdr_write) addr <= WordIn[7:0];
         if (state == DATA && xfer) FrameData <= WordIn[FRAME_WIDTH-1:0];
         if (state == IDLE && xfer && is_sync) begin
            ConfigActive <= 1'b1;
            ConfigDone <= 1'b0;
            ErrBadAddr <= 1'b0;
         end
         if (hdr_end) begin
            ConfigActive <= 1'b0;
            ConfigDone <= 1'b1;
         end
         if (state == DATA && xfer && !in_range) ErrBadAddr <= 1'b1;
      end
   end
endmodule
